msx_io_initiator: RTL and testbench

Bus-master side of the internal MSX I/O bus used by `msx_timer` and the other cartridge peripherals. It accepts single I/O read/write commands from a local command port (CPU bridge or sequencer) and runs one bus transaction per command. It handles the `bus_valid`/`bus_ready` handshake and the separate `bus_rdata_en` read-data strobe, and returns a one-cycle response carrying read data and a timeout flag.

---
 rtl/msx_io_initiator_if.sv | 72 +++++++
 rtl/msx_io_initiator.sv | 211 +++++++++++++++++++++
 tb/tb_msx_io_initiator.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/msx_io_initiator_if.sv
`default_nettype none
// ============================================================================
// Module   : msx_io_initiator_if
// Brief    : Command/response port and MSX I/O bus signals of the initiator.
// Revision : 1.0 - initial release
// ============================================================================
interface msx_io_initiator_if;

    // Local command port
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_address;
    logic [7:0] cmd_wdata;

    // Completion response
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_timeout;

    // MSX I/O bus
    logic       bus_ioreq;
    logic [7:0] bus_address;
    logic       bus_write;
    logic [7:0] bus_wdata;
    logic       bus_valid;
    logic       bus_ready;
    logic [7:0] bus_rdata;
    logic       bus_rdata_en;

    // Initiator view
    modport master (
        input  cmd_valid,
        input  cmd_write,
        input  cmd_address,
        input  cmd_wdata,
        output cmd_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_timeout,
        output bus_ioreq,
        output bus_address,
        output bus_write,
        output bus_wdata,
        output bus_valid,
        input  bus_ready,
        input  bus_rdata,
        input  bus_rdata_en
    );

    // Command source / bus responder view
    modport slave (
        output cmd_valid,
        output cmd_write,
        output cmd_address,
        output cmd_wdata,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_timeout,
        input  bus_ioreq,
        input  bus_address,
        input  bus_write,
        input  bus_wdata,
        input  bus_valid,
        output bus_ready,
        output bus_rdata,
        output bus_rdata_en
    );

endinterface : msx_io_initiator_if
`default_nettype wire

// File: rtl/msx_io_initiator.sv
`default_nettype none
// ============================================================================
// Module   : msx_io_initiator
// Brief    : MSX I/O bus master; one bus transaction per local command.
//            MSX_IO_INITIATOR_TIMEOUT_EN enables the TIMEOUT_CYCLES abort path.
// Revision : 1.0 - initial release
// ============================================================================
module msx_io_initiator
`ifdef MSX_IO_INITIATOR_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 100
)
`endif
(
    input wire                  clk,
    input wire                  reset,
    msx_io_initiator_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_RDWAIT = 2'd2
    } state_t;

    localparam logic [7:0] c_FLOAT_BUS = 8'hFF;

    state_t     r_state;
    logic       r_cmd_ready;
    logic       r_bus_ioreq;
    logic [7:0] r_bus_address;
    logic       r_bus_write;
    logic [7:0] r_bus_wdata;
    logic       r_bus_valid;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_rdata;
    logic       r_got_data;

    state_t     w_state_nxt;
    logic       w_cmd_ready_nxt;
    logic       w_ioreq_nxt;
    logic [7:0] w_addr_nxt;
    logic       w_write_nxt;
    logic [7:0] w_wdata_nxt;
    logic       w_valid_nxt;
    logic       w_rsp_valid_nxt;
    logic [7:0] w_rdata_nxt;
    logic       w_got_nxt;
    logic       w_finish;

`ifdef MSX_IO_INITIATOR_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LIM = c_CNT_W'(TIMEOUT_CYCLES);

    logic [c_CNT_W-1:0] r_tmo_cnt;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_rsp_timeout;
    logic               w_rsp_timeout_nxt;

    assign w_cnt_inc = (r_tmo_cnt == c_TMO_LIM) ? r_tmo_cnt : r_tmo_cnt + c_CNT_W'(1);
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_ready_nxt = r_cmd_ready;
        w_ioreq_nxt     = r_bus_ioreq;
        w_addr_nxt      = r_bus_address;
        w_write_nxt     = r_bus_write;
        w_wdata_nxt     = r_bus_wdata;
        w_valid_nxt     = r_bus_valid;
        w_rsp_valid_nxt = 1'b0;
        w_rdata_nxt     = r_rsp_rdata;
        w_got_nxt       = r_got_data;
        w_finish        = 1'b0;
`ifdef MSX_IO_INITIATOR_TIMEOUT_EN
        w_cnt_nxt         = r_tmo_cnt;
        w_rsp_timeout_nxt = 1'b0;
`endif

        case (r_state)
            S_IDLE: begin
                w_cmd_ready_nxt = 1'b1;
                if (bus.cmd_valid && r_cmd_ready) begin
                    w_cmd_ready_nxt = 1'b0;
                    w_ioreq_nxt     = 1'b1;
                    w_valid_nxt     = 1'b1;
                    w_addr_nxt      = bus.cmd_address;
                    w_write_nxt     = bus.cmd_write;
                    w_wdata_nxt     = bus.cmd_wdata;
                    w_got_nxt       = 1'b0;
                    w_state_nxt     = S_REQ;
                end
            end

            S_REQ: begin
                // Read data may arrive before the request is accepted; first strobe wins.
                if (!r_bus_write && bus.bus_rdata_en && !r_got_data) begin
                    w_rdata_nxt = bus.bus_rdata;
                    w_got_nxt   = 1'b1;
                end
                if (r_bus_valid && bus.bus_ready) begin
                    w_valid_nxt = 1'b0;
                    if (r_bus_write || bus.bus_rdata_en || r_got_data) begin
                        w_finish = 1'b1;
                    end else begin
                        w_wdata_nxt = 8'h00;
                        w_state_nxt = S_RDWAIT;
                    end
                end
            end

            S_RDWAIT: begin
                if (bus.bus_rdata_en) begin
                    w_rdata_nxt = bus.bus_rdata;
                    w_finish    = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_finish) begin
            w_ioreq_nxt     = 1'b0;
            w_addr_nxt      = 8'h00;
            w_write_nxt     = 1'b0;
            w_wdata_nxt     = 8'h00;
            w_valid_nxt     = 1'b0;
            w_rsp_valid_nxt = 1'b1;
            w_cmd_ready_nxt = 1'b1;
            w_state_nxt     = S_IDLE;
        end

`ifdef MSX_IO_INITIATOR_TIMEOUT_EN
        // Count is zero at accept, so the abort lands exactly TIMEOUT_CYCLES after it.
        if (r_state == S_IDLE) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = w_cnt_inc;
            if (!w_finish && (w_cnt_inc == c_TMO_LIM)) begin
                w_ioreq_nxt       = 1'b0;
                w_addr_nxt        = 8'h00;
                w_write_nxt       = 1'b0;
                w_wdata_nxt       = 8'h00;
                w_valid_nxt       = 1'b0;
                w_rsp_valid_nxt   = 1'b1;
                w_rsp_timeout_nxt = 1'b1;
                w_rdata_nxt       = c_FLOAT_BUS;
                w_got_nxt         = 1'b0;
                w_cmd_ready_nxt   = 1'b1;
                w_state_nxt       = S_IDLE;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b1;
            r_bus_ioreq   <= 1'b0;
            r_bus_address <= 8'h00;
            r_bus_write   <= 1'b0;
            r_bus_wdata   <= 8'h00;
            r_bus_valid   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= c_FLOAT_BUS;
            r_got_data    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_bus_ioreq   <= w_ioreq_nxt;
            r_bus_address <= w_addr_nxt;
            r_bus_write   <= w_write_nxt;
            r_bus_wdata   <= w_wdata_nxt;
            r_bus_valid   <= w_valid_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rdata_nxt;
            r_got_data    <= w_got_nxt;
        end
    end

`ifdef MSX_IO_INITIATOR_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt     <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_tmo_cnt     <= w_cnt_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
        end
    end

    assign bus.rsp_timeout = r_rsp_timeout;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.bus_ioreq   = r_bus_ioreq;
    assign bus.bus_address = r_bus_address;
    assign bus.bus_write   = r_bus_write;
    assign bus.bus_wdata   = r_bus_wdata;
    assign bus.bus_valid   = r_bus_valid;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;

endmodule : msx_io_initiator
`default_nettype wire

// File: tb/tb_msx_io_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_msx_io_initiator
// Brief    : Directed self-checking bench for msx_io_initiator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msx_io_initiator;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   n_rsp;

    msx_io_initiator_if ifc ();

    msx_io_initiator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] wd);
        ifc.cmd_valid   = 1'b1;
        ifc.cmd_write   = wr;
        ifc.cmd_address = addr;
        ifc.cmd_wdata   = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        ifc.cmd_valid    = 1'b0;
        ifc.cmd_write    = 1'b0;
        ifc.cmd_address  = 8'h00;
        ifc.cmd_wdata    = 8'h00;
        ifc.bus_ready    = 1'b0;
        ifc.bus_rdata    = 8'h00;
        ifc.bus_rdata_en = 1'b0;
        reset = 1'b1;
        repeat (3) step();

        check("rst_cmd_ready", ifc.cmd_ready, 1);
        check("rst_ioreq", ifc.bus_ioreq, 0);
        check("rst_valid", ifc.bus_valid, 0);
        check("rst_addr", ifc.bus_address, 0);
        check("rst_rsp_valid", ifc.rsp_valid, 0);
        check("rst_rsp_rdata", ifc.rsp_rdata, 8'hFF);
        check("rst_rsp_timeout", ifc.rsp_timeout, 0);
        reset = 1'b0;
        step();

        // Write 0xB1 <- 0x80, responder always ready
        issue(1'b1, 8'hB1, 8'h80);
        ifc.bus_ready = 1'b1;
        step();
        ifc.cmd_valid = 1'b0;
        check("wr_valid_e0", ifc.bus_valid, 1);
        check("wr_ioreq_e0", ifc.bus_ioreq, 1);
        check("wr_addr", ifc.bus_address, 8'hB1);
        check("wr_wdata", ifc.bus_wdata, 8'h80);
        check("wr_write", ifc.bus_write, 1);
        check("wr_cmd_ready_e0", ifc.cmd_ready, 0);
        step();
        check("wr_valid_e1", ifc.bus_valid, 0);
        check("wr_rsp_valid", ifc.rsp_valid, 1);
        check("wr_rsp_timeout", ifc.rsp_timeout, 0);
        check("wr_ioreq_e1", ifc.bus_ioreq, 0);
        check("wr_cmd_ready_e1", ifc.cmd_ready, 1);
        step();
        check("wr_rsp_pulse_end", ifc.rsp_valid, 0);

        // Read 0xB3: ready after 3 cycles, strobe 2 cycles after that
        ifc.bus_ready = 1'b0;
        issue(1'b0, 8'hB3, 8'h00);
        step();
        ifc.cmd_valid = 1'b0;
        check("rd_ioreq_e0", ifc.bus_ioreq, 1);
        step();
        step();
        check("rd_valid_wait", ifc.bus_valid, 1);
        ifc.bus_ready = 1'b1;
        step();
        ifc.bus_ready = 1'b0;
        check("rd_valid_dropped", ifc.bus_valid, 0);
        check("rd_ioreq_held", ifc.bus_ioreq, 1);
        check("rd_addr_held", ifc.bus_address, 8'hB3);
        check("rd_no_rsp_yet", ifc.rsp_valid, 0);
        step();
        check("rd_ioreq_rdwait", ifc.bus_ioreq, 1);
        ifc.bus_rdata_en = 1'b1;
        ifc.bus_rdata    = 8'h0A;
        step();
        ifc.bus_rdata_en = 1'b0;
        check("rd_rsp_valid", ifc.rsp_valid, 1);
        check("rd_rsp_rdata", ifc.rsp_rdata, 8'h0A);
        check("rd_ioreq_end", ifc.bus_ioreq, 0);
        check("rd_addr_end", ifc.bus_address, 0);
        step();
        check("rd_rsp_pulse_end", ifc.rsp_valid, 0);

        // Read with data one cycle before ready; later strobe of 0x55 ignored
        issue(1'b0, 8'h10, 8'h00);
        step();
        ifc.cmd_valid    = 1'b0;
        ifc.bus_rdata_en = 1'b1;
        ifc.bus_rdata    = 8'h14;
        step();
        check("early_no_rsp", ifc.rsp_valid, 0);
        check("early_valid_held", ifc.bus_valid, 1);
        ifc.bus_rdata    = 8'h55;
        ifc.bus_ready    = 1'b1;
        step();
        ifc.bus_ready    = 1'b0;
        check("early_rsp_valid", ifc.rsp_valid, 1);
        check("early_rsp_rdata", ifc.rsp_rdata, 8'h14);
        step();
        ifc.bus_rdata_en = 1'b0;
        check("idle_strobe_ignored", ifc.rsp_rdata, 8'h14);
        check("idle_no_rsp", ifc.rsp_valid, 0);

        // Responder never ready
        issue(1'b0, 8'h20, 8'h00);
        step();
        ifc.cmd_valid = 1'b0;
        n_rsp = 0;
`ifdef MSX_IO_INITIATOR_TIMEOUT_EN
        for (int k = 1; k < 100; k++) begin
            step();
            if (ifc.rsp_valid) n_rsp++;
        end
        check("tmo_no_early_rsp", n_rsp, 0);
        step();
        check("tmo_rsp_valid", ifc.rsp_valid, 1);
        check("tmo_flag", ifc.rsp_timeout, 1);
        check("tmo_rdata", ifc.rsp_rdata, 8'hFF);
        check("tmo_ioreq", ifc.bus_ioreq, 0);
        check("tmo_valid", ifc.bus_valid, 0);
        check("tmo_cmd_ready", ifc.cmd_ready, 1);
        step();
        check("tmo_pulse_end", ifc.rsp_valid, 0);
`else
        for (int k = 1; k < 120; k++) begin
            step();
            if (ifc.rsp_valid) n_rsp++;
        end
        check("notmo_no_rsp", n_rsp, 0);
        check("notmo_valid_held", ifc.bus_valid, 1);
        ifc.bus_ready    = 1'b1;
        ifc.bus_rdata_en = 1'b1;
        ifc.bus_rdata    = 8'h3C;
        step();
        ifc.bus_ready    = 1'b0;
        ifc.bus_rdata_en = 1'b0;
        check("notmo_rsp_valid", ifc.rsp_valid, 1);
        check("notmo_rdata", ifc.rsp_rdata, 8'h3C);
        check("notmo_flag", ifc.rsp_timeout, 0);
        step();
`endif
        // Following write completes normally
        ifc.bus_ready = 1'b1;
        issue(1'b1, 8'hB2, 8'h33);
        step();
        ifc.cmd_valid = 1'b0;
        check("post_wr_addr", ifc.bus_address, 8'hB2);
        step();
        check("post_wr_rsp", ifc.rsp_valid, 1);
        check("post_wr_flag", ifc.rsp_timeout, 0);
        step();

        // Back-to-back writes to 0xB0..0xB3 with cmd_valid held
        n_rsp = 0;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 8'hB0 + 8'(i), 8'h40 + 8'(i));
            step();
            check("b2b_addr", ifc.bus_address, 8'hB0 + 8'(i));
            check("b2b_wdata", ifc.bus_wdata, 8'h40 + 8'(i));
            step();
            if (ifc.rsp_valid) n_rsp++;
        end
        ifc.cmd_valid = 1'b0;
        check("b2b_rsp_count", n_rsp, 4);
        step();
        check("b2b_idle", ifc.bus_ioreq, 0);

        // Asynchronous reset while waiting for read data
        issue(1'b0, 8'h30, 8'h00);
        step();
        ifc.cmd_valid = 1'b0;
        step();
        ifc.bus_ready = 1'b0;
        check("rdwait_ioreq", ifc.bus_ioreq, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_ioreq", ifc.bus_ioreq, 0);
        check("arst_addr", ifc.bus_address, 0);
        check("arst_valid", ifc.bus_valid, 0);
        check("arst_cmd_ready", ifc.cmd_ready, 1);
        check("arst_rsp_valid", ifc.rsp_valid, 0);
        reset = 1'b0;
        ifc.bus_rdata_en = 1'b1;
        ifc.bus_rdata    = 8'h77;
        step();
        ifc.bus_rdata_en = 1'b0;
        check("arst_no_rsp", ifc.rsp_valid, 0);
        check("arst_rdata", ifc.rsp_rdata, 8'hFF);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_msx_io_initiator
`default_nettype wire
